// File: rtl/fetch_unit.sv
// rtl/fetch_unit.sv - instruction fetch stage: PC ownership, timed memory read, write-back PC commit
module fetch_unit #(
    parameter int                  PC_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC = 32'h0000_0000,
    parameter int                  TIMEOUT  = 16
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                enable_fetch,
    input  logic                enable_writeback,
    input  logic                do_branch,
    input  logic                do_jump,
    input  logic [13:0]         imm_14bit,
    input  logic [23:0]         imm_24bit,
    output logic [PC_WIDTH-1:0] im_addr,
    output logic                im_read,
    input  logic [31:0]         im_rdata,
    input  logic                im_ready,
    output logic [31:0]         instruction,
    output logic [PC_WIDTH-1:0] pc,
    output logic                fetch_busy,
    output logic                fetch_error
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_WAIT = 1'b1;

    // Last wait-counter value before the fetch is abandoned (TIMEOUT is 2..255).
    localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

    logic [0:0]          state_q, state_d;
    logic [7:0]          cnt_q, cnt_d;
    logic [PC_WIDTH-1:0] addr_q, addr_d;
    logic [31:0]         instr_q, instr_d;
    logic                err_q, err_d;
    logic [PC_WIDTH-1:0] pc_q, pc_d;

    // Displacements are in halfwords: sign-extend to PC width, then scale by 2.
    logic [PC_WIDTH-1:0] jump_off;
    logic [PC_WIDTH-1:0] branch_off;

    assign jump_off   = PC_WIDTH'($signed(imm_24bit)) << 1;
    assign branch_off = PC_WIDTH'($signed(imm_14bit)) << 1;

    // Fetch sequencing: request latches the address, then wait for ready or time out.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        instr_d = instr_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (enable_fetch) begin
                    addr_d  = pc_q;
                    cnt_d   = 8'd0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (im_ready) begin
                    instr_d = im_rdata;
                    state_d = S_IDLE;
                end else if (cnt_q == CNT_LAST) begin
                    instr_d = 32'h0;
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end else begin
                    cnt_d = cnt_q + 8'd1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // PC commit at write-back; jump outranks branch, otherwise fall through by one word.
    always_comb begin
        pc_d = pc_q;
        if (enable_writeback) begin
            if (do_jump) begin
                pc_d = pc_q + jump_off;
            end else if (do_branch) begin
                pc_d = pc_q + branch_off;
            end else begin
                pc_d = pc_q + PC_WIDTH'(4);
            end
        end
    end

    // State registers; reset aborts any fetch in flight.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            addr_q  <= RESET_PC;
            instr_q <= 32'h0;
            err_q   <= 1'b0;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            instr_q <= instr_d;
            err_q   <= err_d;
            pc_q    <= pc_d;
        end
    end

    assign im_addr     = addr_q;
    assign im_read     = (state_q == S_WAIT);
    assign fetch_busy  = (state_q == S_WAIT);
    assign instruction = instr_q;
    assign pc          = pc_q;
    assign fetch_error = err_q;

endmodule

// File: tb/tb_fetch_unit.sv
// tb/tb_fetch_unit.sv - self-checking bench for fetch_unit against a cycle-count reference model
module tb_fetch_unit;

    localparam int TO = 16;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        enable_fetch = 1'b0;
    logic        enable_writeback = 1'b0;
    logic        do_branch = 1'b0;
    logic        do_jump = 1'b0;
    logic [13:0] imm_14bit = '0;
    logic [23:0] imm_24bit = '0;
    logic [31:0] im_addr;
    logic        im_read;
    logic [31:0] im_rdata = '0;
    logic        im_ready = 1'b0;
    logic [31:0] instruction;
    logic [31:0] pc;
    logic        fetch_busy;
    logic        fetch_error;

    fetch_unit #(
        .PC_WIDTH(32),
        .RESET_PC(32'h0000_0000),
        .TIMEOUT (TO)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .enable_fetch    (enable_fetch),
        .enable_writeback(enable_writeback),
        .do_branch       (do_branch),
        .do_jump         (do_jump),
        .imm_14bit       (imm_14bit),
        .imm_24bit       (imm_24bit),
        .im_addr         (im_addr),
        .im_read         (im_read),
        .im_rdata        (im_rdata),
        .im_ready        (im_ready),
        .instruction     (instruction),
        .pc              (pc),
        .fetch_busy      (fetch_busy),
        .fetch_error     (fetch_error)
    );

    always #5 clock = ~clock;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    function automatic void chk(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endfunction

    // Reference model: a fetch is described by its request cycle; it ends on
    // ready, or is abandoned exactly TO edges after the request edge.
    logic [31:0] m_pc    = 32'h0;
    logic [31:0] m_addr  = 32'h0;
    logic [31:0] m_instr = 32'h0;
    bit          m_busy  = 1'b0;
    bit          m_err   = 1'b0;
    int          m_cycle = 0;
    int          m_start = 0;

    function automatic logic [31:0] next_pc(logic [31:0] cur, bit br, bit jp,
                                            logic [13:0] i14, logic [23:0] i24);
        int off;
        if (jp)      off = int'($signed(i24)) * 2;
        else if (br) off = int'($signed(i14)) * 2;
        else         off = 4;
        return cur + 32'(off);
    endfunction

    always @(posedge clock or posedge reset) begin
        if (reset) begin
            m_pc    <= 32'h0;
            m_addr  <= 32'h0;
            m_instr <= 32'h0;
            m_busy  <= 1'b0;
            m_err   <= 1'b0;
        end else begin
            m_cycle <= m_cycle + 1;
            if (m_busy) begin
                if (im_ready) begin
                    m_instr <= im_rdata;
                    m_busy  <= 1'b0;
                end else if (m_cycle + 1 - m_start == TO) begin
                    m_instr <= 32'h0;
                    m_err   <= 1'b1;
                    m_busy  <= 1'b0;
                end
            end else if (enable_fetch) begin
                m_addr  <= m_pc;
                m_start <= m_cycle + 1;
                m_busy  <= 1'b1;
            end
            if (enable_writeback)
                m_pc <= next_pc(m_pc, do_branch, do_jump, imm_14bit, imm_24bit);
        end
    end

    // Compare every output against the model away from the active edge.
    always @(negedge clock) begin
        if (chk_en) begin
            chk("pc", pc, m_pc);
            chk("im_addr", im_addr, m_addr);
            chk("instruction", instruction, m_instr);
            chk("im_read", 32'(im_read), 32'(m_busy));
            chk("fetch_busy", 32'(fetch_busy), 32'(m_busy));
            chk("fetch_error", 32'(fetch_error), 32'(m_err));
        end
    end

    task automatic cyc(input bit ef, input bit ewb, input bit br, input bit jp,
                       input logic [13:0] i14, input logic [23:0] i24,
                       input bit rdy, input logic [31:0] rd);
        enable_fetch     = ef;
        enable_writeback = ewb;
        do_branch        = br;
        do_jump          = jp;
        imm_14bit        = i14;
        imm_24bit        = i24;
        im_ready         = rdy;
        im_rdata         = rd;
        @(negedge clock);
    endtask

    task automatic nop();
        cyc(0, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
    endtask

    int busy_n;

    initial begin
        #1 reset = 1'b1;
        chk_en = 1'b1;
        repeat (2) @(negedge clock);
        chk("rst_pc", pc, 32'h0);
        chk("rst_im_addr", im_addr, 32'h0);
        chk("rst_instruction", instruction, 32'h0);
        chk("rst_im_read", 32'(im_read), 32'h0);
        chk("rst_fetch_error", 32'(fetch_error), 32'h0);
        reset = 1'b0;
        nop();

        // Reset while a read is outstanding, then a stale ready.
        cyc(1, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        chk("midfetch_im_read", 32'(im_read), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("async_rst_im_read", 32'(im_read), 32'h0);
        chk("async_rst_busy", 32'(fetch_busy), 32'h0);
        @(negedge clock);
        reset = 1'b0;
        cyc(0, 0, 0, 0, 14'h0, 24'h0, 1, 32'hDEAD_BEEF);
        chk("late_ready_instr", instruction, 32'h0);

        // Zero-wait fetch and sequential commit.
        cyc(1, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        chk("seq_im_addr", im_addr, 32'h0);
        cyc(0, 0, 0, 0, 14'h0, 24'h0, 1, 32'h0A10_0005);
        chk("seq_instr", instruction, 32'h0A10_0005);
        cyc(0, 1, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        chk("seq_pc", pc, 32'h4);

        // Branch and jump targets.
        cyc(0, 1, 0, 1, 14'h0, 24'h00007E, 0, 32'h0);
        chk("jump_pc_100", pc, 32'h100);
        cyc(0, 1, 1, 0, 14'h3FFE, 24'h0, 0, 32'h0);
        chk("branch_back", pc, 32'hFC);
        cyc(0, 1, 0, 1, 14'h0, 24'h000002, 0, 32'h0);
        chk("jump_pc_100b", pc, 32'h100);
        cyc(0, 1, 1, 1, 14'h0005, 24'h000010, 0, 32'h0);
        chk("jump_over_branch", pc, 32'h120);

        // Five busy cycles, with a request pulsed mid-wait.
        busy_n = 0;
        cyc(1, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        busy_n += int'(fetch_busy);
        cyc(0, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        busy_n += int'(fetch_busy);
        cyc(1, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        busy_n += int'(fetch_busy);
        cyc(0, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        busy_n += int'(fetch_busy);
        cyc(0, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        busy_n += int'(fetch_busy);
        cyc(0, 0, 0, 0, 14'h0, 24'h0, 1, 32'h55AA_1234);
        chk("wait_busy_cycles", 32'(busy_n), 32'd5);
        chk("wait_instr", instruction, 32'h55AA_1234);
        chk("wait_no_error", 32'(fetch_error), 32'h0);
        nop();
        chk("no_queued_request", 32'(im_read), 32'h0);

        // Ready arriving on the timeout edge wins.
        cyc(1, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        repeat (TO - 1) cyc(0, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        cyc(0, 0, 0, 0, 14'h0, 24'h0, 1, 32'h600D_600D);
        chk("edge_ready_instr", instruction, 32'h600D_600D);
        chk("edge_ready_no_err", 32'(fetch_error), 32'h0);

        // Timeout abort, then a successful fetch keeps the sticky flag.
        cyc(1, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        repeat (TO - 1) cyc(0, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        chk("pre_timeout_busy", 32'(fetch_busy), 32'h1);
        cyc(0, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        chk("timeout_busy", 32'(fetch_busy), 32'h0);
        chk("timeout_err", 32'(fetch_error), 32'h1);
        chk("timeout_instr", instruction, 32'h0);
        cyc(1, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        cyc(0, 0, 0, 0, 14'h0, 24'h0, 1, 32'h1234_5678);
        chk("after_to_instr", instruction, 32'h1234_5678);
        chk("err_sticky", 32'(fetch_error), 32'h1);

        // Wrap-around and commit during an in-flight fetch.
        cyc(0, 1, 0, 1, 14'h0, 24'hFFFF6E, 0, 32'h0);
        chk("pc_top", pc, 32'hFFFF_FFFC);
        cyc(1, 0, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        cyc(0, 1, 0, 0, 14'h0, 24'h0, 0, 32'h0);
        chk("wrap_pc", pc, 32'h0);
        chk("wrap_im_addr_held", im_addr, 32'hFFFF_FFFC);
        cyc(0, 0, 0, 0, 14'h0, 24'h0, 1, 32'hCAFE_F00D);
        chk("wrap_instr", instruction, 32'hCAFE_F00D);

        // Randomized traffic, including occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 299) == 0) begin
                #2 reset = 1'b1;
                #2 reset = 1'b0;
            end
            cyc(($urandom_range(0, 3) == 0), ($urandom_range(0, 3) == 0),
                1'($urandom), 1'($urandom_range(0, 2) == 0),
                14'($urandom), 24'($urandom),
                ($urandom_range(0, 5) == 0), $urandom);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction-fetch stage that sits directly upstream of the controller. It owns the program counter and issues a read to instruction memory when the controller pulses `enable_fetch`. It latches the returned word onto `instruction`, which feeds the controller's decode fields. At write-back it commits the next PC: sequential, conditional-branch or jump target, supplied by the execute path.

## Interface
- `PC_WIDTH`, default 32: width of PC and instruction-memory address.
- `RESET_PC`, default 32'h0000_0000: PC value after reset.
- `TIMEOUT`, default 16: maximum cycles to wait for `im_ready` before aborting a fetch (legal range 2..255).

Ports (one clock; reset is asynchronous and active-high):
- `clock`  in  1  system clock; all state changes on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `enable_fetch`  in  1  one-cycle fetch request from the controller's S0 state.
- `enable_writeback`  in  1  one-cycle PC commit strobe from the controller's S4 state.
- `do_branch`  in  1  conditional branch taken, valid while `enable_writeback`=1.
- `do_jump`  in  1  unconditional jump, valid while `enable_writeback`=1.
- `imm_14bit`  in  14  branch displacement in halfwords, signed.
- `imm_24bit`  in  24  jump displacement in halfwords, signed.
- `im_addr`  out  PC_WIDTH  instruction-memory address.
- `im_read`  out  1  instruction-memory read request.
- `im_rdata`  in  32  instruction-memory read data, valid with `im_ready`.
- `im_ready`  in  1  read data valid.
- `instruction`  out  32  latched instruction word, to the controller.
- `pc`  out  PC_WIDTH  current program counter.
- `fetch_busy`  out  1  fetch in flight.
- `fetch_error`  out  1  sticky timeout flag.

## Operation
- The state machine has two states.
- IDLE:
  - `im_read`=0.
  - When `enable_fetch`=1: latch `im_addr`<=`pc`, clear the wait counter, go to WAIT.
- WAIT:
  - `im_read`=1 and `fetch_busy`=1.
  - When `im_ready`=1: `instruction`<=`im_rdata`, go to IDLE.
  - Otherwise, when wait counter = TIMEOUT-1: `instruction`<=32'h0, `fetch_error`<=1, go to IDLE.
  - Otherwise the counter increments.
  - `enable_fetch` during WAIT is ignored; it is not queued.
- `im_ready` in IDLE is ignored.
- PC commit happens on a cycle with `enable_writeback`=1, independent of fetch state. Target priority:
  - `do_jump`: `pc` + (sext(`imm_24bit`) << 1).
  - `do_branch`: `pc` + (sext(`imm_14bit`) << 1).
  - Neither: `pc` + 4.
- Arithmetic is modulo 2^PC_WIDTH; wrap-around is silent.
- A commit during WAIT does not disturb the in-flight fetch, because `im_addr` was latched at the request.
- `fetch_error` clears only on reset.
- Reset values: `pc`=RESET_PC, `im_addr`=RESET_PC, `instruction`=0, `im_read`=0, `fetch_busy`=0, `fetch_error`=0, counter=0, state IDLE.
- Reset mid-fetch aborts immediately; late `im_ready` after reset is ignored.

## Timing
- All outputs are registered.
- `enable_fetch` sampled at edge N: `im_read`/`fetch_busy` go high after edge N.
- `im_ready` sampled high at edge N+k (k≥1): `instruction` updates and `fetch_busy` drops after edge N+k.
- Zero-wait memory (ready in the first WAIT cycle) gives 2-edge fetch latency.
- Timeout abort completes after edge N+TIMEOUT; `fetch_error` is visible in the same cycle `fetch_busy` drops.
- `enable_writeback` at edge M: new `pc` is visible after edge M.
- `pc` is stable at all other times.
- `do_branch`/`do_jump` are don't-care when `enable_writeback`=0.
- `im_ready` and timeout on the same edge: `im_ready` wins, no error.

## Test plan
- **Reset:** reset while `im_read`=1 -> after async reset, `pc`=0, `im_read`=0, `instruction`=0. A later `im_ready` with `im_rdata`=32'hDEADBEEF leaves `instruction`=0.
- **Sequential:**
  - Fetch at `pc`=0 with zero-wait ready returning 32'h0A10_0005 -> `im_addr`=0, `instruction`=32'h0A10_0005 two edges after `enable_fetch`.
  - `enable_writeback` with no branch -> `pc`=4.
- **Branch/jump:**
  - `pc`=32'h100, `do_branch`=1, `imm_14bit`=14'h3FFE (−2) -> `pc`=32'hFC.
  - `do_jump`=1 and `do_branch`=1 together, `imm_24bit`=24'h000010 -> `pc`=32'h120.
- **Wait states:** `im_ready` delayed 5 cycles -> `fetch_busy` high 5 cycles, `fetch_error`=0. A second `enable_fetch` pulsed mid-wait produces no extra request.
- **Timeout:** `im_ready` held low, TIMEOUT=16 -> after 16 WAIT cycles `instruction`=0 and `fetch_error`=1. A following successful fetch keeps `fetch_error`=1.
- **Wrap:** `pc`=32'hFFFF_FFFC, sequential commit -> `pc`=0. A commit during WAIT leaves `im_addr` at the old value.
